// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle,
// followed by a single sign-fix cycle that writes HI/LO and pulses done.
module muldiv_hilo_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             op_valid,
   input  logic [1:0]       op,
   input  logic             unsign,
   input  logic [WIDTH-1:0] reg_read_a,
   input  logic [WIDTH-1:0] reg_read_b,
   input  logic             hilo_read,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
   typedef enum logic [1:0] {OP_MULT, OP_DIV, OP_MTHI, OP_MTLO} op_t;

   state_t             state, state_next;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;        // mult: {product_hi, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   mag_a;      // multiplicand magnitude (mult), unused by div after load
   logic [WIDTH-1:0]   mag_b;      // divisor magnitude (div)
   logic [WIDTH-1:0]   raw_a;      // unmodified dividend for divide-by-zero
   logic               is_div;
   logic               neg_q;      // negate product / quotient
   logic               neg_r;      // negate remainder (dividend sign)
   logic               div_zero;

   logic               accept;
   logic               neg_a_in, neg_b_in;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Operand magnitudes and one iteration of each algorithm
   always_comb begin
      accept   = op_valid & ~busy;
      neg_a_in = ~unsign & reg_read_a[WIDTH-1];
      neg_b_in = ~unsign & reg_read_b[WIDTH-1];
      abs_a    = neg_a_in ? -reg_read_a : reg_read_a;
      abs_b    = neg_b_in ? -reg_read_b : reg_read_b;
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      // Shifted remainder needs WIDTH+1 bits; the difference always fits WIDTH bits when taken.
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      div_ge   = rem_sh >= {1'b0, mag_b};
      div_sub  = rem_sh[WIDTH-1:0] - mag_b;
      div_next = div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (accept && !op[1]) state_next = S_RUN;
         S_RUN:  if (cnt == '0)        state_next = S_FIX;
         S_FIX:                        state_next = S_IDLE;
         default:                      state_next = S_IDLE;
      endcase
   end

   // Status outputs
   always_comb begin
      busy  = (state != S_IDLE);
      stall = busy & (op_valid | hilo_read);
   end

   // Datapath: operand latch, iteration, HI/LO writeback and done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         acc      <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         raw_a    <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == S_FIX);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op_t'(op))
                     OP_MTHI: hi <= reg_read_a;
                     OP_MTLO: lo <= reg_read_a;
                     default: begin
                        is_div   <= op[0];
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        raw_a    <= reg_read_a;
                        neg_q    <= neg_a_in ^ neg_b_in;
                        neg_r    <= neg_a_in;
                        div_zero <= (reg_read_b == '0);
                        acc      <= op[0] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        cnt      <= CW'(WIDTH - 1);
                     end
                  endcase
               end
            end
            S_RUN: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               if (!is_div) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= raw_a;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
